// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
//
// Purpose : Shared types and defaults for the data-memory arbiter that sits
//           between the CPU EX/MEM register and DataMemory. It holds the
//           owner-state encoding, the grant encoding, the default starvation
//           and lock limits, and a helper that maps a grant to the next owner
//           state.
//
// Contents:
//   STARVE_LIMIT_DEFAULT - contested cycles the CPU may win back to back
//   LOCK_MAX_DEFAULT     - locked DMA beats before the CPU gets one slot
//   arb_state_t          - owner of the previous cycle (IDLE/CPU/DMA/DMA_LOCK)
//   grant_t              - owner of the current cycle (NONE/CPU/DMA)
//   next_owner()         - next owner state from this cycle's grant
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

  localparam int STARVE_LIMIT_DEFAULT = 4;
  localparam int LOCK_MAX_DEFAULT     = 8;

  // The state records who owned the memory in the previous cycle.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CPU      = 2'd1,
    ST_DMA      = 2'd2,
    ST_DMA_LOCK = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_DMA  = 2'd2
  } grant_t;

  // A DMA grant with dma_lock set opens or continues a locked burst.
  function automatic arb_state_t next_owner(input grant_t gnt, input logic dma_lock);
    arb_state_t nxt;
    nxt = ST_IDLE;
    case (gnt)
      GNT_CPU: nxt = ST_CPU;
      GNT_DMA: nxt = dma_lock ? ST_DMA_LOCK : ST_DMA;
      default: nxt = ST_IDLE;
    endcase
    return nxt;
  endfunction

endpackage : dmem_arbiter_pkg

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//
// Purpose : Bundles the CPU port, the DMA port and the DataMemory port of the
//           data-memory arbiter.
//
// Modports:
//   slave  - the arbiter: takes CPU/DMA requests and mem_rdata, drives the
//            grant/stall, read-data returns and the DataMemory controls.
//   master - the surrounding system (CPU, DMA engine, DataMemory model).
//
// Signals:
//   cpu_req/cpu_we/cpu_addr/cpu_wdata   CPU MEM-stage access
//   cpu_rdata/cpu_stall                 CPU load data (same cycle) and stall
//   dma_req/dma_we/dma_addr/dma_wdata   DMA access
//   dma_lock                            DMA asks for burst ownership
//   dma_gnt                             DMA granted this cycle
//   dma_rdata/dma_rvalid                registered DMA read return
//   mem_addr/mem_wdata/mem_read/mem_write  to DataMemory
//   mem_rdata                           combinational DataMemory read data
// -----------------------------------------------------------------------------
interface dmem_arbiter_if;

  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_lock;
  logic        dma_gnt;
  logic [31:0] dma_rdata;
  logic        dma_rvalid;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
    output dma_gnt, dma_rdata, dma_rvalid,
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata
  );

endinterface : dmem_arbiter_if

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Purpose : Shares the single-port DataMemory between the CPU MEM stage and a
//           DMA/peripheral port. The grant is combinational so the CPU sees
//           its load data in the same cycle; a stalled CPU holds its request
//           (cpu_stall feeds the hazard unit). DMA read data comes back one
//           cycle after the grant through a register.
//
//           Arbitration order for each cycle:
//             1. an unfinished locked DMA burst keeps the memory;
//             2. when both ask, the CPU wins unless it has already won
//                STARVE_LIMIT contested cycles in a row;
//             3. a lone requester is granted.
//
// Parameters:
//   STARVE_LIMIT - contested CPU wins before DMA is forced through
//   LOCK_MAX     - locked DMA beats before the CPU is given one slot
//
// Ports:
//   sysclk - clock
//   reset  - asynchronous, active-high; all outputs read 0 while asserted
//   bus    - dmem_arbiter_if.slave (CPU, DMA and DataMemory signals)
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
  parameter int LOCK_MAX     = LOCK_MAX_DEFAULT
) (
  input  logic          sysclk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int LOCK_W   = $clog2(LOCK_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_LIMIT);
  localparam logic [LOCK_W-1:0]   LOCK_TOP   = LOCK_W'(LOCK_MAX);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  arb_state_t          r_state;
  logic [STARVE_W-1:0] r_starve_cnt;
  logic [LOCK_W-1:0]   r_lock_cnt;
  logic [31:0]         r_dma_rdata;
  logic                r_dma_rvalid;

  // ---------------------------------------------------------------------------
  // Grant decision
  // ---------------------------------------------------------------------------
  grant_t      w_grant;
  logic        w_both;
  logic        w_lock_hold;
  logic        w_gnt_cpu;
  logic        w_gnt_dma;
  logic        w_gnt_any;
  logic        w_gnt_we;
  logic        w_dma_read;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;

  assign w_both      = bus.cpu_req & bus.dma_req;
  assign w_lock_hold = (r_state == ST_DMA_LOCK) && bus.dma_req && (r_lock_cnt < LOCK_TOP);

  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave it unassigned and infer a latch.
    w_grant = GNT_NONE;
    if (reset) begin
      // Grants are suppressed while reset is held, whatever the requests.
      w_grant = GNT_NONE;
    end else if (w_lock_hold) begin
      w_grant = GNT_DMA;
    end else if (w_both) begin
      w_grant = (r_starve_cnt == STARVE_TOP) ? GNT_DMA : GNT_CPU;
    end else if (bus.cpu_req) begin
      w_grant = GNT_CPU;
    end else if (bus.dma_req) begin
      w_grant = GNT_DMA;
    end
  end

  assign w_gnt_cpu  = (w_grant == GNT_CPU);
  assign w_gnt_dma  = (w_grant == GNT_DMA);
  assign w_gnt_any  = w_gnt_cpu | w_gnt_dma;
  assign w_dma_read = w_gnt_dma & ~bus.dma_we;

  // Steer the granted requester onto the memory port; all zero when idle.
  always_comb begin
    w_addr   = '0;
    w_wdata  = '0;
    w_gnt_we = 1'b0;
    case (w_grant)
      GNT_CPU: begin
        w_addr   = bus.cpu_addr;
        w_wdata  = bus.cpu_wdata;
        w_gnt_we = bus.cpu_we;
      end
      GNT_DMA: begin
        w_addr   = bus.dma_addr;
        w_wdata  = bus.dma_wdata;
        w_gnt_we = bus.dma_we;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.mem_addr  = w_addr;
  assign bus.mem_wdata = w_wdata;
  assign bus.mem_read  = w_gnt_any & ~w_gnt_we;
  assign bus.mem_write = w_gnt_any &  w_gnt_we;

  assign bus.cpu_rdata = (w_gnt_cpu & ~bus.cpu_we) ? bus.mem_rdata : '0;
  // cpu_req alone would raise the stall during reset, so gate it explicitly.
  assign bus.cpu_stall = bus.cpu_req & ~w_gnt_cpu & ~reset;
  assign bus.dma_gnt   = w_gnt_dma;

  assign bus.dma_rdata  = r_dma_rdata;
  assign bus.dma_rvalid = r_dma_rvalid;

  // ---------------------------------------------------------------------------
  // Owner FSM, fairness counters and DMA read return
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_starve_cnt <= '0;
      r_lock_cnt   <= '0;
      r_dma_rdata  <= '0;
      r_dma_rvalid <= 1'b0;
    end else begin
      r_state <= next_owner(w_grant, bus.dma_lock);

      // Consecutive contested CPU wins, saturating at the limit.
      if (w_both && w_gnt_cpu) begin
        if (r_starve_cnt != STARVE_TOP) begin
          r_starve_cnt <= r_starve_cnt + 1'b1;
        end
      end else if (w_gnt_dma || !bus.dma_req) begin
        r_starve_cnt <= '0;
      end

      // Beats of the current locked burst. The opening beat counts, so a
      // burst is cut after exactly LOCK_MAX beats if the CPU is waiting; with
      // no CPU request the count sits at LOCK_MAX and the burst carries on.
      if (w_gnt_dma && bus.dma_lock) begin
        if (r_lock_cnt != LOCK_TOP) begin
          r_lock_cnt <= r_lock_cnt + 1'b1;
        end
      end else begin
        r_lock_cnt <= '0;
      end

      // DMA read data is captured on the grant edge; rvalid is a 1-cycle pulse.
      r_dma_rvalid <= w_dma_read;
      if (w_dma_read) begin
        r_dma_rdata <= bus.mem_rdata;
      end
    end
  end

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Self-checking bench for dmem_arbiter with default parameters
// (STARVE_LIMIT=4, LOCK_MAX=8). Each cycle carries a hand-derived expected
// owner ('N' none, 'C' CPU, 'D' DMA); the combinational outputs follow from
// that owner and the driven inputs. Every DMA read grant pushes the expected
// read data onto a scoreboard queue, popped when dma_rvalid is due next cycle.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic sysclk = 1'b0;
  logic reset  = 1'b0;

  dmem_arbiter_if bus ();

  dmem_arbiter dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 sysclk = ~sysclk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] sb_rdata[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive(input logic creq, input logic cwe, input logic [31:0] caddr,
                       input logic [31:0] cwd, input logic dreq, input logic dwe,
                       input logic [31:0] daddr, input logic [31:0] dwd,
                       input logic dlock, input logic [31:0] mrd);
    bus.cpu_req   = creq;
    bus.cpu_we    = cwe;
    bus.cpu_addr  = caddr;
    bus.cpu_wdata = cwd;
    bus.dma_req   = dreq;
    bus.dma_we    = dwe;
    bus.dma_addr  = daddr;
    bus.dma_wdata = dwd;
    bus.dma_lock  = dlock;
    bus.mem_rdata = mrd;
  endtask

  // Compare every output against the expected owner g for the current inputs.
  task automatic check_outputs(input byte g);
    logic        is_c;
    logic        is_d;
    logic        we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_rvalid;
    logic [31:0] e_rdata;
    is_c    = (g == "C");
    is_d    = (g == "D");
    we      = is_c ? bus.cpu_we    : (is_d ? bus.dma_we    : 1'b0);
    e_addr  = is_c ? bus.cpu_addr  : (is_d ? bus.dma_addr  : 32'h0);
    e_wdata = is_c ? bus.cpu_wdata : (is_d ? bus.dma_wdata : 32'h0);

    check("dma_gnt",   32'(bus.dma_gnt),   32'(is_d));
    check("cpu_stall", 32'(bus.cpu_stall), 32'(bus.cpu_req & ~is_c));
    check("mem_addr",  bus.mem_addr,  e_addr);
    check("mem_wdata", bus.mem_wdata, e_wdata);
    check("mem_read",  32'(bus.mem_read),  32'((is_c | is_d) & ~we));
    check("mem_write", 32'(bus.mem_write), 32'((is_c | is_d) & we));
    check("cpu_rdata", bus.cpu_rdata, (is_c && !bus.cpu_we) ? bus.mem_rdata : 32'h0);

    e_rvalid = (sb_rdata.size() != 0);
    check("dma_rvalid", 32'(bus.dma_rvalid), 32'(e_rvalid));
    if (e_rvalid) begin
      e_rdata = sb_rdata.pop_front();
      check("dma_rdata", bus.dma_rdata, e_rdata);
    end
    if (is_d && !bus.dma_we) begin
      sb_rdata.push_back(bus.mem_rdata);
    end
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, return at posedge+1.
  task automatic step(input byte g, input logic creq, input logic cwe,
                      input logic [31:0] caddr, input logic [31:0] cwd,
                      input logic dreq, input logic dwe, input logic [31:0] daddr,
                      input logic [31:0] dwd, input logic dlock, input logic [31:0] mrd);
    drive(creq, cwe, caddr, cwd, dreq, dwe, daddr, dwd, dlock, mrd);
    @(negedge sysclk);
    check_outputs(g);
    @(posedge sysclk);
    #1;
  endtask

  task automatic idle_cycle();
    step("N", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // Assert reset with the current inputs left in place; every output must be 0.
  task automatic do_reset();
    reset = 1'b1;
    #2;
    check("rst_dma_gnt",    32'(bus.dma_gnt),    32'h0);
    check("rst_cpu_stall",  32'(bus.cpu_stall),  32'h0);
    check("rst_mem_read",   32'(bus.mem_read),   32'h0);
    check("rst_mem_write",  32'(bus.mem_write),  32'h0);
    check("rst_mem_addr",   bus.mem_addr,        32'h0);
    check("rst_mem_wdata",  bus.mem_wdata,       32'h0);
    check("rst_cpu_rdata",  bus.cpu_rdata,       32'h0);
    check("rst_dma_rvalid", 32'(bus.dma_rvalid), 32'h0);
    check("rst_dma_rdata",  bus.dma_rdata,       32'h0);
    sb_rdata.delete();
    @(posedge sysclk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, n_checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    string pat;

    // Reset with both ports requesting reads of live data.
    drive(1'b1, 1'b0, 32'h100, 32'h1, 1'b1, 1'b0, 32'h200, 32'h2, 1'b1, 32'hCAFE_F00D);
    #1;
    do_reset();

    // CPU read, no DMA.
    step("C", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'hDEAD_BEEF);
    // CPU write.
    step("C", 1'b1, 1'b1, 32'h20, 32'hA5A5_A5A5, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    // DMA read alone: granted now, data one cycle later, then rvalid drops.
    step("D", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h1234_5678);
    idle_cycle();
    idle_cycle();

    // Contested, unlocked: four CPU wins, then DMA forced through.
    pat = "CCCCDCCCCD";
    for (int i = 0; i < pat.len(); i++) begin
      step(pat[i], 1'b1, 1'(i & 1), 32'(32'h1000 + i * 4), 32'(32'hC000 + i),
           1'b1, 1'b0, 32'(32'h2000 + i * 4), 32'(32'hD000 + i), 1'b0,
           32'(32'h5000_0000 + i));
    end
    idle_cycle();

    // DMA write alone: granted, no read return.
    step("D", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h44, 32'h77, 1'b0, 32'hFFFF);
    idle_cycle();

    // Locked burst, CPU joins on beat 2: 8 beats, one CPU slot, then CPU has
    // three more contested wins before the starvation limit forces DMA.
    pat = "DDDDDDDDCCCCD";
    for (int i = 0; i < pat.len(); i++) begin
      step(pat[i], 1'(i >= 1), 1'b0, 32'(32'h3000 + i * 4), 32'h0,
           1'b1, 1'b0, 32'(32'h4000 + i * 4), 32'h0, 1'b1,
           32'(32'h6000_0000 + i));
    end
    idle_cycle();

    // Locked burst without CPU runs past LOCK_MAX; a late CPU request is then
    // served at once because the lock count sits at its limit.
    pat = "DDDDDDDDDDC";
    for (int i = 0; i < pat.len(); i++) begin
      step(pat[i], 1'(i == pat.len() - 1), 1'b0, 32'h80, 32'h0,
           1'b1, 1'b1, 32'(32'h5000 + i * 4), 32'(32'hB000 + i), 1'b1,
           32'(32'h7000_0000 + i));
    end
    idle_cycle();

    // Reset during the third locked beat, then both request: CPU first.
    step("D", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h600, 32'h0, 1'b1, 32'h8000_0001);
    step("D", 1'b1, 1'b0, 32'h90, 32'h0, 1'b1, 1'b0, 32'h604, 32'h0, 1'b1, 32'h8000_0002);
    drive(1'b1, 1'b0, 32'h90, 32'h0, 1'b1, 1'b0, 32'h608, 32'h0, 1'b1, 32'h8000_0003);
    @(negedge sysclk);
    check_outputs("D");
    do_reset();
    step("C", 1'b1, 1'b0, 32'h90, 32'h0, 1'b1, 1'b0, 32'h608, 32'h0, 1'b1, 32'h9000_0000);
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_dmem_arbiter
